// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD init/text sequencer and its nibble writer.
package lcd_pkg;

  // One LCD bus command: {RS, D7, D6, D5, D4}.
  localparam int unsigned CMD_W  = 5;
  localparam int unsigned RS_BIT = 4;

  // Default bus timing in system clock cycles, sized for a 50 MHz clock.
  localparam int unsigned T_SETUP_DEF  = 2;   // >= 40 ns data setup before E rises
  localparam int unsigned T_E_HIGH_DEF = 12;  // >= 230 ns enable high time
  localparam int unsigned T_HOLD_DEF   = 2;   // >= 10 ns data hold after E falls

  // Execution delays used by the sequencer, expressed in clock cycles.
  localparam int unsigned CLK_FREQ_DEF = 50_000_000;
  localparam int unsigned CYC_PER_US   = CLK_FREQ_DEF / 1_000_000;
  localparam int unsigned t1_uS        = CYC_PER_US;
  localparam int unsigned t10us        = 10 * CYC_PER_US;
  localparam int unsigned t53us        = 53 * CYC_PER_US;
  localparam int unsigned t100us       = 100 * CYC_PER_US;
  localparam int unsigned t3ms         = 3000 * CYC_PER_US;
  localparam int unsigned t4_1ms       = 4100 * CYC_PER_US;

  // Transfer phases of the nibble writer.
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    E_HIGH,
    HOLD,
    WAIT,
    DONE
  } lcd_state_t;

endpackage

// File: rtl/lcd_cycle_timer.sv
// Loadable down-counter that times every phase of a bus transfer.
module lcd_cycle_timer #(
  parameter int DELAY_W = 21
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [DELAY_W-1:0] load_value_i,
  output logic [DELAY_W-1:0] value_o,
  output logic               zero_o
);

  logic [DELAY_W-1:0] count_q;

  // Load a new phase length, otherwise count down and park at zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_value_i;
    end else if (count_q != '0) begin
      count_q <= count_q - DELAY_W'(1);
    end
  end

  assign value_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/lcd_nibble_writer.sv
// Drives one {RS, D7..D4} nibble onto the HD44780 4-bit bus with setup, enable
// pulse and hold timing, waits the command's execution delay, then pulses commandDone.
module lcd_nibble_writer
  import lcd_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int T_SETUP  = 2,
  parameter int T_E_HIGH = 12,
  parameter int T_HOLD   = 2,
  parameter int DELAY_W  = 21
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               sendCommand,
  input  logic [CMD_W-1:0]   command,
  input  logic [DELAY_W-1:0] commandDelay,
  output logic               commandDone,
  output logic [CMD_W-1:0]   LCD_D,
  output logic               LCD_E,
  output logic               busy
);

  // Zero-length phases would break the LCD timing; a non-positive clock is meaningless.
  if (T_SETUP < 1 || T_E_HIGH < 1 || T_HOLD < 1 || CLK_FREQ < 1) begin : g_bad_timing
    $error("lcd_nibble_writer: T_SETUP, T_E_HIGH, T_HOLD and CLK_FREQ must all be >= 1");
  end

  lcd_state_t         state_q, state_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic               armed_q, armed_d;
  logic               lcd_e_q, done_q, busy_q;

  logic               tmr_load;
  logic [DELAY_W-1:0] tmr_load_value;
  logic [DELAY_W-1:0] tmr_value;
  logic               tmr_zero;
  logic               unused_tmr_value;

  lcd_cycle_timer #(
    .DELAY_W (DELAY_W)
  ) u_timer (
    .clk_i        (CLK),
    .rst_i        (RST),
    .load_i       (tmr_load),
    .load_value_i (tmr_load_value),
    .value_o      (tmr_value),
    .zero_o       (tmr_zero)
  );

  // Phase sequencing only needs the zero flag; the count itself is for debug visibility.
  assign unused_tmr_value = ^tmr_value;

  // Next-state, latch and timer-load decisions for the transfer phases.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch can be inferred.
    state_d        = state_q;
    cmd_d          = cmd_q;
    delay_d        = delay_q;
    armed_d        = armed_q;
    tmr_load       = 1'b0;
    tmr_load_value = '0;

    unique case (state_q)
      IDLE: begin
        if (sendCommand && armed_q) begin
          cmd_d          = command;
          delay_d        = commandDelay;
          tmr_load       = 1'b1;
          tmr_load_value = DELAY_W'(T_SETUP - 1);
          state_d        = SETUP;
        end else if (!sendCommand) begin
          // Request dropped between commands: the next rising request may launch.
          armed_d = 1'b1;
        end
      end
      SETUP: begin
        if (tmr_zero) begin
          tmr_load       = 1'b1;
          tmr_load_value = DELAY_W'(T_E_HIGH - 1);
          state_d        = E_HIGH;
        end
      end
      E_HIGH: begin
        if (tmr_zero) begin
          tmr_load       = 1'b1;
          tmr_load_value = DELAY_W'(T_HOLD - 1);
          state_d        = HOLD;
        end
      end
      HOLD: begin
        if (tmr_zero) begin
          if (delay_q == '0) begin
            state_d = DONE;
          end else begin
            tmr_load       = 1'b1;
            tmr_load_value = delay_q - DELAY_W'(1);
            state_d        = WAIT;
          end
        end
      end
      WAIT: begin
        if (tmr_zero) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // A request still held high must not start a second transfer.
        armed_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched command and registered bus outputs; reset drops LCD_E at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      delay_q <= '0;
      armed_q <= 1'b1;
      lcd_e_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      delay_q <= delay_d;
      armed_q <= armed_d;
      lcd_e_q <= (state_d == E_HIGH);
      done_q  <= (state_d == DONE);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign LCD_D       = cmd_q;
  assign LCD_E       = lcd_e_q;
  assign commandDone = done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Self-checking bench for lcd_nibble_writer: per-cycle comparison against a
// timeline model, table-driven transfers, hand-written corner cases, random traffic.
module tb_lcd_nibble_writer;

  localparam int DW = 21;
  localparam int TS = 2;
  localparam int TE = 12;
  localparam int TH = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          sendCommand;
  logic [4:0]    command;
  logic [DW-1:0] commandDelay;
  logic          commandDone;
  logic [4:0]    LCD_D;
  logic          LCD_E;
  logic          busy;

  lcd_nibble_writer #(
    .CLK_FREQ (50_000_000),
    .T_SETUP  (TS),
    .T_E_HIGH (TE),
    .T_HOLD   (TH),
    .DELAY_W  (DW)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .sendCommand  (sendCommand),
    .command      (command),
    .commandDelay (commandDelay),
    .commandDone  (commandDone),
    .LCD_D        (LCD_D),
    .LCD_E        (LCD_E),
    .busy         (busy)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Timeline model: a transfer started at edge ks occupies cycles rel = 1..m_len
  // after it, where m_len = 1 + setup + E-high + hold + delay.
  int         edge_n  = 0;
  int         ks      = -1;
  int         m_len   = 0;
  logic       m_armed = 1'b1;
  logic [4:0] m_cmd   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int rel_prev;
    edge_n++;
    if (RST) begin
      ks = -1; m_len = 0; m_armed = 1'b1; m_cmd = '0;
      return;
    end
    rel_prev = (ks < 0) ? 0 : edge_n - ks;
    if (ks < 0 || rel_prev > m_len) begin
      if (sendCommand && m_armed) begin
        ks    = edge_n;
        m_cmd = command;
        m_len = 1 + TS + TE + TH + int'(commandDelay);
      end else if (!sendCommand) begin
        m_armed = 1'b1;
      end
    end else if (rel_prev == m_len) begin
      m_armed = 1'b0;
    end
  endtask

  task automatic compare_outputs();
    int   rel;
    logic act;
    act = (ks >= 0);
    rel = edge_n - ks + 1;
    check("busy", busy,        act && rel <= m_len);
    check("lcd_e", LCD_E,      act && rel >= 1 + TS && rel <= TS + TE);
    check("done", commandDone, act && rel == m_len);
    check("lcd_d", LCD_D,      m_cmd);
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare_outputs();
  endtask

  // Full transfer with done-latency, bus-value and E-pulse-count checks, then a
  // single-cycle request drop in IDLE so the next transfer can launch immediately.
  task automatic run_xfer(input logic [4:0] cmd, input int dly, input int hold,
                          input int exp_lat, input string name);
    int   lat;
    bit   seen;
    int   pulses;
    logic prev_e;
    command = cmd; commandDelay = DW'(dly); sendCommand = 1'b1;
    lat = 0; seen = 0; pulses = 0; prev_e = 1'b0;
    for (int i = 1; i <= dly + 200 && !seen; i++) begin
      tick();
      if (LCD_E && !prev_e) pulses++;
      prev_e = LCD_E;
      if (commandDone) begin seen = 1; lat = i; end
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_bus"}, LCD_D, cmd);
    repeat (hold + 1) begin
      tick();
      if (LCD_E && !prev_e) pulses++;
      prev_e = LCD_E;
    end
    check({name, "_epulses"}, pulses, 1);
    sendCommand = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [4:0] cmd;
    int         delay;
    int         hold;
    int         exp_lat;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int   lat;
    bit   seen;
    int   dones;

    vecs[0] = '{cmd: 5'b00011, delay: 500,   hold: 0,   exp_lat: 517};
    vecs[1] = '{cmd: 5'b10111, delay: 0,     hold: 100, exp_lat: 17};
    vecs[2] = '{cmd: 5'b01010, delay: 1,     hold: 3,   exp_lat: 18};
    vecs[3] = '{cmd: 5'b11111, delay: 35000, hold: 0,   exp_lat: 35017};

    RST = 1'b1; sendCommand = 1'b0; command = '0; commandDelay = '0;
    repeat (3) tick();
    check("reset_e", LCD_E, 0);
    check("reset_d", LCD_D, 0);
    RST = 1'b0;
    repeat (2) tick();

    // Table-driven transfers; vecs[1] holds the request high 100 cycles past done.
    for (int v = 0; v < 4; v++) begin
      run_xfer(vecs[v].cmd, vecs[v].delay, vecs[v].hold, vecs[v].exp_lat, $sformatf("vec%0d", v));
    end
    check("rs_bit_after_table", {31'd0, LCD_D[lcd_pkg::RS_BIT]}, 1);

    // Inputs change and the request drops during E_HIGH: original values rule.
    command = 5'b00101; commandDelay = DW'(3); sendCommand = 1'b1;
    repeat (5) tick();
    check("midchg_e_high", LCD_E, 1);
    command = 5'b01111; commandDelay = DW'(5); sendCommand = 1'b0;
    lat = 0; seen = 0;
    for (int i = 6; i <= 300 && !seen; i++) begin
      tick();
      if (commandDone) begin seen = 1; lat = i; end
      else check("midchg_bus", LCD_D, 5'b00101);
    end
    check("midchg_latency", lat, 20);
    check("midchg_bus_after", LCD_D, 5'b00101);
    repeat (3) tick();

    // Asynchronous reset in the middle of the enable pulse.
    command = 5'b11010; commandDelay = DW'(10); sendCommand = 1'b1;
    repeat (6) tick();
    check("rst_pre_e", LCD_E, 1);
    #2 RST = 1'b1;
    #1;
    check("rst_async_e", LCD_E, 0);
    check("rst_async_d", LCD_D, 0);
    check("rst_async_busy", busy, 0);
    sendCommand = 1'b0;
    @(negedge CLK);
    tick();
    RST = 1'b0;
    dones = 0;
    repeat (40) begin
      tick();
      if (commandDone) dones++;
    end
    check("rst_no_done", dones, 0);

    // Long wait exercising the upper counter bits.
    run_xfer(5'b00001, lcd_pkg::t1_uS * 700, 0, 17 + lcd_pkg::t1_uS * 700, "longwait");

    // Random traffic: request mostly high with frequent drops, inputs churning.
    dones = 0;
    for (int i = 0; i < 3000; i++) begin
      sendCommand  = ($urandom_range(0, 4) != 0);
      command      = 5'($urandom);
      commandDelay = DW'($urandom_range(0, 25));
      tick();
      if (commandDone) dones++;
    end
    check("random_made_progress", {31'd0, dones > 20}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
